// File: rtl/pong_vga_renderer.sv
// Pong video back end: 640x480@60 VGA timing, frame-latched
// object positions, and a registered ball/paddle/net renderer.
module pong_vga_renderer #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int BALL_SIZE     = 10,
    parameter int PADDLE_X      = 0,
    parameter int PADDLE_WIDTH  = 10,
    parameter int PADDLE_HEIGHT = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       display_on,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] NET_L  = 10'(H_ACTIVE / 2 - 1);
    localparam logic [9:0] NET_R  = 10'(H_ACTIVE / 2);

    localparam logic [9:0] BX_RST = 10'(H_ACTIVE / 2);
    localparam logic [9:0] BY_RST = 10'(V_ACTIVE / 2);
    localparam logic [9:0] PY_RST = 10'(V_ACTIVE / 2 - PADDLE_HEIGHT / 2);

    localparam logic [10:0] BALL_W = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_L  = 11'(PADDLE_X);
    localparam logic [10:0] PAD_W  = 11'(PADDLE_WIDTH);
    localparam logic [10:0] PAD_H  = 11'(PADDLE_HEIGHT);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [9:0]  bx_q, by_q, py_q;
    logic [10:0] h11, v11;
    logic        active, ball_hit, pad_hit, net_hit;
    logic        hsync_d, vsync_d, tick_d;
    logic [5:0]  rgb_d;
    logic        hsync_q, vsync_q, de_q, tick_q;
    logic [5:0]  rgb_q;

    // Next raster position: h wraps at line end and carries into v.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Pixel decode for the stage-0 position; sums kept 11 bits wide so
    // objects past the right/bottom edge clip instead of wrapping to 0.
    always_comb begin
        h11      = {1'b0, h_q};
        v11      = {1'b0, v_q};
        active   = (h_q < H_ACT) && (v_q < V_ACT);
        ball_hit = (h11 >= {1'b0, bx_q}) && (h11 < {1'b0, bx_q} + BALL_W) &&
                   (v11 >= {1'b0, by_q}) && (v11 < {1'b0, by_q} + BALL_W);
        pad_hit  = ((h11 - PAD_L) < PAD_W) &&
                   (v11 >= {1'b0, py_q}) && (v11 < {1'b0, py_q} + PAD_H);
        net_hit  = ((h_q == NET_L) || (h_q == NET_R)) && !v_q[4];
        hsync_d  = !((h_q >= HS_BEG) && (h_q <= HS_END));
        vsync_d  = !((v_q >= VS_BEG) && (v_q <= VS_END));
        tick_d   = (h_q == '0) && (v_q == V_ACT);
        rgb_d    = 6'b00_00_00;
        if (!active)       rgb_d = 6'b00_00_00;
        else if (ball_hit) rgb_d = 6'b11_11_11;
        else if (pad_hit)  rgb_d = 6'b00_11_00;
        else if (net_hit)  rgb_d = 6'b01_01_01;
    end

    // Stage-0 raster counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Positions sampled once per frame at the start of vertical blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bx_q <= BX_RST;
            by_q <= BY_RST;
            py_q <= PY_RST;
        end else if (tick_d) begin
            bx_q <= ball_x;
            by_q <= ball_y;
            py_q <= paddle_y;
        end
    end

    // Stage-1 output registers keep sync and colour aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            de_q    <= active;
            tick_q  <= tick_d;
        end
    end

    assign hpos       = h_q;
    assign vpos       = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign r          = rgb_q[5:4];
    assign g          = rgb_q[3:2];
    assign b          = rgb_q[1:0];
    assign display_on = de_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/pong_vga_renderer.md
# pong_vga_renderer

Video back end of the Pong game: generates 640x480@60 Hz VGA timing from a 25.175 MHz pixel clock and draws ball, paddle and centre net from the game-logic position registers. Positions are sampled once per frame, at the start of vertical blanking, so the picture never tears. A per-frame tick is exported so the game logic can step once per frame instead of using a free-running divider. Outputs drive the 2-bit-per-channel VGA PMOD on `uo_out`.

## Interface

**Parameters**

- `H_ACTIVE` = 640: visible pixels per line.
- `H_FRONT` = 16, `H_SYNC` = 96, `H_BACK` = 48: horizontal blanking, in pixels. Line period = 800.
- `V_ACTIVE` = 480: visible lines.
- `V_FRONT` = 10, `V_SYNC` = 2, `V_BACK` = 33: vertical blanking, in lines. Frame period = 525 lines.
- `BALL_SIZE` = 10: ball square edge, in pixels.
- `PADDLE_X` = 0: paddle left column.
- `PADDLE_WIDTH` = 10, `PADDLE_HEIGHT` = 60: paddle size.

**Ports**

- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ball_x`  in  10  ball left column, from game logic.
- `ball_y`  in  10  ball top row, from game logic.
- `paddle_y`  in  10  paddle top row, from game logic.
- `hpos`  out  10  current horizontal counter, 0..799.
- `vpos`  out  10  current vertical counter, 0..524.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `r`, `g`, `b`  out  2 each  colour.
- `display_on`  out  1  high in the active area.
- `frame_tick`  out  1  one-cycle pulse per frame.

## Operation

**Counters (stage 0)**
- `h` increments every clock and wraps 799→0.
- On that wrap, `v` increments and wraps 524→0.
- `hpos`/`vpos` are `h`/`v` directly.

**Position latch**
- Trigger: stage-0 counters at `h==0 && v==V_ACTIVE` (480).
- On that edge, `bx`, `by` and `py` load from `ball_x`, `ball_y` and `paddle_y`.
- Input changes at any other time have no effect on the picture.

**Output stage (stage 1)**
All of `hsync`, `vsync`, `r`, `g`, `b`, `display_on` and `frame_tick` are registered from the stage-0 values.
- `hsync` = 0 iff 656 ≤ h ≤ 751.
- `vsync` = 0 iff 490 ≤ v ≤ 491.
- `display_on` = (h < 640 && v < 480).
- `frame_tick` = 1 iff h==0 && v==480.

**Colour, decided in priority order**
1. Not `display_on` → 0/0/0.
2. Ball: `bx` ≤ h < `bx`+BALL_SIZE and `by` ≤ v < `by`+BALL_SIZE → 3/3/3.
3. Paddle: PADDLE_X ≤ h < PADDLE_X+PADDLE_WIDTH and `py` ≤ v < `py`+PADDLE_HEIGHT → 0/3/0.
4. Net: h ∈ {319, 320} and `v[4]`==0 → 1/1/1.
5. Otherwise → 0/0/0.

**Width rules**
- Right-hand sums (`bx`+BALL_SIZE, `py`+PADDLE_HEIGHT) are formed in 11 bits, so no wrap occurs.
- A ball at `bx`=1020 does not reappear at h=0..5.
- Objects partially or fully outside the active area are clipped, never wrapped.

**Reset**
- `h`, `v` = 0.
- `bx` = 320, `by` = 240, `py` = 210.
- `hsync` = `vsync` = 1.
- `r`, `g`, `b` = 0; `display_on` = 0; `frame_tick` = 0.

**Reset mid-frame**
- Applies on the next edge, regardless of counter state.
- The frame restarts at (0,0) on the first clock after `rst_n` rises.

## Timing

- Stage-1 outputs lag `hpos`/`vpos` by exactly 1 clock. Sync and colour are mutually aligned.
- Line = 800 clocks; frame = 420 000 clocks.
- `hsync` low for 96 consecutive clocks per line; `vsync` low for 1600 consecutive clocks per frame.
- `frame_tick` is high for exactly 1 clock per frame. Its edge is the same edge on which the latch loads.
- New positions become visible from line 0 of the next frame, 45 lines after the latch.
- Game logic stepping on `frame_tick` has a full blanking period (45×800 clocks) to update its registers.

## Test plan

1. **Reset.** Hold `rst_n`=0 for 5 clocks, then release.
   → During reset: `hsync`=`vsync`=1, rgb=0, `frame_tick`=0.
   → First clock after release: `hpos`=`vpos`=0.
2. **Sync timing.** Run 2 frames after reset.
   → `hsync` falls 657 clocks after release and stays low 96 clocks.
   → Line period 800 clocks.
   → `vsync` low for exactly 1600 clocks, beginning with the output cycle for h=0, v=490.
   → `frame_tick` pulses 420 000 clocks apart.
3. **Ball drawing and latch.** Set ball_x=100, ball_y=50 before a `frame_tick`.
   → Next frame: pixels (100,50) and (109,59) are 3/3/3; pixels (110,50) and (99,50) are 0/0/0.
   → Change ball_x to 200 at v=100: no change in the current frame; ball moves in the following frame.
4. **Paddle and priority.** Set paddle_y=40, ball_x=5, ball_y=45.
   → Pixel (5,45) is 3/3/3 (ball wins).
   → Pixels (0,40) and (9,99) are 0/3/0.
   → Pixel (0,100) is 0/0/0.
5. **Net and clipping.** Set ball_x=1020, ball_y=470.
   → No ball pixels in columns 0..5.
   → Rows 470..479 show no ball.
   → Pixel (319,0) is 1/1/1; pixel (319,16) is 0/0/0.
6. **Reset mid-frame.** Assert `rst_n`=0 at h=400, v=300 for 1 clock.
   → Counters return to 0.
   → Latched positions revert to 320/240/210.
   → Next `frame_tick` arrives 384 000 clocks after release.
